// File: rtl/imul_iter_pkg.sv
// Shared types and helpers for the iterative multiplier.
// Digit width is restricted to radix 2, 4 or 16.
package imul_iter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    NORM  = 2'd2
  } state_e;

  function automatic bit digit_ok(int d);
    return (d == 1) || (d == 2) || (d == 4);
  endfunction

  function automatic int num_digits(int w, int d);
    return (w + d - 1) / d;
  endfunction

endpackage

// File: rtl/imul_iter_zeroenc.sv
// Trailing-zero encoder: index of the lowest set bit.
// Fed a bit-reversed word, it yields the leading-zero count.
module zeroenc #(
  parameter int iwidth     = 105,
  parameter int shiftwidth = 7
) (
  input  logic [iwidth-1:0]     data_i,
  output logic [shiftwidth-1:0] shift_o
);

  always_comb begin
    shift_o = '0;
    for (int i = iwidth - 1; i >= 0; i--) begin
      if (data_i[i]) shift_o = shiftwidth'(i);
    end
  end

endmodule

// File: rtl/imul_iter.sv
// Iterative unsigned multiplier, one radix-2^DIGIT_BITS digit per cycle,
// with leading-one shift, overflow and zero flags.
module imul_iter
  import imul_iter_pkg::*;
#(
  parameter int WIDTH      = 53,
  parameter int DIGIT_BITS = 4,
  parameter int SHIFTW     = 7
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_ena,
  input  logic               i_abort,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_busy,
  output logic               o_rdy,
  output logic [2*WIDTH-1:0] o_result,
  output logic [SHIFTW-1:0]  o_shift,
  output logic               o_overflow,
  output logic               o_zero
);

  localparam int N  = num_digits(WIDTH, DIGIT_BITS);
  localparam int BW = N * DIGIT_BITS;
  localparam int PW = 2 * WIDTH;
  localparam int MW = WIDTH + DIGIT_BITS;
  localparam int ND = 1 << DIGIT_BITS;
  localparam int CW = $clog2(N + 1);

  if (!digit_ok(DIGIT_BITS)) begin : g_bad_digit
    $error("imul_iter: DIGIT_BITS must be 1, 2 or 4");
  end

  typedef struct packed {
    state_e            st;
    logic [WIDTH-1:0]  a;
    logic [BW-1:0]     b;
    logic [PW-1:0]     sum;
    logic [CW-1:0]     cnt;
    logic              rdy;
    logic [PW-1:0]     res;
    logic [SHIFTW-1:0] shift;
    logic              ovf;
    logic              zero;
  } regs_t;

  regs_t r_q, r_d;

  // k*a from shifts and adds; 2^j-1 multiples use one subtract
  function automatic logic [MW-1:0] mul_k(
    input logic [WIDTH-1:0] a,
    input int               k
  );
    logic [MW-1:0] ax;
    logic [MW-1:0] acc;
    int            j;
    bit            pow;
    ax  = MW'(a);
    acc = '0;
    j   = 0;
    pow = 1'b0;
    for (int i = 0; i <= DIGIT_BITS; i++) begin
      if ((1 << i) == k + 1) begin
        pow = 1'b1;
        j   = i;
      end
    end
    if (k > 2 && pow) begin
      acc = (ax << j) - ax;
    end else begin
      for (int i = 0; i < DIGIT_BITS; i++) begin
        if (k[i]) acc = acc + (ax << i);
      end
    end
    return acc;
  endfunction

  logic [MW-1:0] mult [ND];

  for (genvar g = 0; g < ND; g++) begin : g_mult
    assign mult[g] = mul_k(r_q.a, g);
  end

  logic [DIGIT_BITS-1:0] dig;
  logic [PW-1:0]         addend;
  logic [PW-2:0]         rev;
  logic [SHIFTW-1:0]     zshift;

  assign dig    = r_q.b[BW-1 -: DIGIT_BITS];
  assign addend = PW'(mult[dig]);

  for (genvar g = 0; g < PW - 1; g++) begin : g_rev
    assign rev[g] = r_q.sum[PW-2-g];
  end

  zeroenc #(
    .iwidth     (PW - 1),
    .shiftwidth (SHIFTW)
  ) u_zenc (
    .data_i  (rev),
    .shift_o (zshift)
  );

  always_comb begin
    r_d     = r_q;
    r_d.rdy = 1'b0;
    unique case (r_q.st)
      IDLE: begin
        if (i_ena && !i_abort) begin
          r_d.st  = ACCUM;
          r_d.a   = i_a;
          r_d.b   = BW'(i_b);
          r_d.sum = '0;
          r_d.cnt = '0;
        end
      end
      ACCUM: begin
        if (i_abort) begin
          r_d.st = IDLE;
        end else begin
          r_d.sum = (r_q.sum << DIGIT_BITS) + addend;
          r_d.b   = r_q.b << DIGIT_BITS;
          r_d.cnt = r_q.cnt + 1'b1;
          if (r_q.cnt == CW'(N - 1)) r_d.st = NORM;
        end
      end
      NORM: begin
        r_d.st = IDLE;
        if (!i_abort) begin
          r_d.rdy  = 1'b1;
          r_d.res  = r_q.sum;
          r_d.ovf  = r_q.sum[PW-1];
          r_d.zero = (r_q.sum == '0);
          if (r_q.sum[PW-1])
            r_d.shift = '1;
          else if (r_q.sum == '0)
            r_d.shift = '0;
          else
            r_d.shift = zshift;
        end
      end
      default: r_d.st = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_q <= '0;
    else       r_q <= r_d;
  end

  assign o_busy     = (r_q.st != IDLE);
  assign o_rdy      = r_q.rdy;
  assign o_result   = r_q.res;
  assign o_shift    = r_q.shift;
  assign o_overflow = r_q.ovf;
  assign o_zero     = r_q.zero;

endmodule

// File: tb/tb_imul_iter.sv
// Scoreboard bench for imul_iter in three configurations:
// 53/4, 8/2 and 24/1.
module tb_imul_iter;

  typedef struct packed {
    logic [127:0] res;
    logic [7:0]   sh;
    logic         ov;
    logic         z;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tot = 0;
  int   n_bad = 0;
  int   tst [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic          ena53, ab53, busy53, rdy53, ov53, z53;
  logic [52:0]   a53, b53;
  logic [105:0]  res53;
  logic [6:0]    sh53;

  logic          ena8, ab8, busy8, rdy8, ov8, z8;
  logic [7:0]    a8, b8;
  logic [15:0]   res8;
  logic [3:0]    sh8;

  logic          ena24, ab24, busy24, rdy24, ov24, z24;
  logic [23:0]   a24, b24;
  logic [47:0]   res24;
  logic [5:0]    sh24;

  imul_iter #(.WIDTH(53), .DIGIT_BITS(4), .SHIFTW(7)) u53 (
    .i_clk(clk), .i_rst(rst), .i_ena(ena53), .i_abort(ab53),
    .i_a(a53), .i_b(b53), .o_busy(busy53), .o_rdy(rdy53),
    .o_result(res53), .o_shift(sh53), .o_overflow(ov53), .o_zero(z53)
  );

  imul_iter #(.WIDTH(8), .DIGIT_BITS(2), .SHIFTW(4)) u8 (
    .i_clk(clk), .i_rst(rst), .i_ena(ena8), .i_abort(ab8),
    .i_a(a8), .i_b(b8), .o_busy(busy8), .o_rdy(rdy8),
    .o_result(res8), .o_shift(sh8), .o_overflow(ov8), .o_zero(z8)
  );

  imul_iter #(.WIDTH(24), .DIGIT_BITS(1), .SHIFTW(6)) u24 (
    .i_clk(clk), .i_rst(rst), .i_ena(ena24), .i_abort(ab24),
    .i_a(a24), .i_b(b24), .o_busy(busy24), .o_rdy(rdy24),
    .o_result(res24), .o_shift(sh24), .o_overflow(ov24), .o_zero(z24)
  );

  exp_t q53 [$];
  exp_t q8  [$];
  exp_t q24 [$];

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int w, input int sw,
                                 input logic [127:0] a,
                                 input logic [127:0] b);
    exp_t e;
    logic [127:0] p;
    p    = a * b;
    e.res = p;
    e.ov  = p[2*w-1];
    e.z   = (p == 0);
    e.sh  = '0;
    if (e.ov) begin
      e.sh = 8'((1 << sw) - 1);
    end else if (!e.z) begin
      for (int i = 0; i < 2 * w - 1; i++)
        if (p[i]) e.sh = 8'(2 * w - 2 - i);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rdy53) begin
      if (q53.size() == 0) chk("rdy53_spur", rdy53, 0);
      else begin
        e = q53.pop_front();
        chk("res53", res53, e.res);
        chk("sh53", sh53, e.sh);
        chk("ov53", ov53, e.ov);
        chk("z53", z53, e.z);
      end
    end
    if (rdy8) begin
      if (q8.size() == 0) chk("rdy8_spur", rdy8, 0);
      else begin
        e = q8.pop_front();
        chk("res8", res8, e.res);
        chk("sh8", sh8, e.sh);
        chk("ov8", ov8, e.ov);
        chk("z8", z8, e.z);
      end
    end
    if (rdy24) begin
      if (q24.size() == 0) chk("rdy24_spur", rdy24, 0);
      else begin
        e = q24.pop_front();
        chk("res24", res24, e.res);
        chk("sh24", sh24, e.sh);
        chk("ov24", ov24, e.ov);
        chk("z24", z24, e.z);
      end
    end
  end

  function automatic logic rdy_of(input int w);
    case (w)
      0:       return rdy53;
      1:       return rdy8;
      default: return rdy24;
    endcase
  endfunction

  task automatic go53(input logic [127:0] a, input logic [127:0] b,
                      input bit push);
    a53 = a[52:0];
    b53 = b[52:0];
    ena53 = 1'b1;
    tst[0] = cyc;
    if (push) q53.push_back(model(53, 7, 128'(a[52:0]), 128'(b[52:0])));
    @(negedge clk);
    ena53 = 1'b0;
  endtask

  task automatic go8(input logic [127:0] a, input logic [127:0] b);
    a8 = a[7:0];
    b8 = b[7:0];
    ena8 = 1'b1;
    tst[1] = cyc;
    q8.push_back(model(8, 4, 128'(a[7:0]), 128'(b[7:0])));
    @(negedge clk);
    ena8 = 1'b0;
  endtask

  task automatic go24(input logic [127:0] a, input logic [127:0] b);
    a24 = a[23:0];
    b24 = b[23:0];
    ena24 = 1'b1;
    tst[2] = cyc;
    q24.push_back(model(24, 6, 128'(a[23:0]), 128'(b[23:0])));
    @(negedge clk);
    ena24 = 1'b0;
  endtask

  task automatic wt(input int w, output int lat);
    int n;
    n = 0;
    while (!rdy_of(w) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rdy_timeout", rdy_of(w), 1);
    lat = cyc - tst[w];
  endtask

  logic [127:0] max53, p52, hold;
  logic [23:0]  ra, rb;
  int           lat;

  initial begin
    rst = 1'b1;
    {ena53, ab53, ena8, ab8, ena24, ab24} = '0;
    a53 = '0; b53 = '0; a8 = '0; b8 = '0; a24 = '0; b24 = '0;
    max53 = (128'd1 << 53) - 1;
    p52   = 128'd1 << 52;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy53, 0);
    chk("rst_rdy", rdy53, 0);
    chk("rst_res", res53, 0);
    chk("rst_sh", sh53, 0);
    chk("rst_ov", ov53, 0);
    chk("rst_z", z53, 0);

    go53(p52, p52, 1);
    chk("busy_c1", busy53, 1);
    wt(0, lat);
    chk("lat53", lat, 16);
    chk("busy_at_rdy", busy53, 0);
    chk("res_2p104", res53, 128'd1 << 104);

    go53(max53, max53, 1);
    wt(0, lat);
    chk("sh_max", sh53, 7'h7f);
    go53(1, 1, 1);
    wt(0, lat);
    chk("sh_one", sh53, 104);
    go53(0, 5, 1);
    wt(0, lat);

    go53(128'd123456789012345, 128'd987654321, 1);
    @(negedge clk);
    a53 = 53'd77; b53 = 53'd99; ena53 = 1'b1;
    @(negedge clk);
    ena53 = 1'b0;
    wt(0, lat);
    chk("lat_ign", lat, 16);
    hold = 128'd123456789012345 * 128'd987654321;

    go53(128'd55, 128'd66, 0);
    repeat (4) @(negedge clk);
    ab53 = 1'b1;
    @(negedge clk);
    ab53 = 1'b0;
    chk("abort_busy", busy53, 0);
    repeat (20) @(negedge clk);
    chk("abort_hold", res53, hold);

    go53(max53, 128'd3, 1);
    wt(0, lat);
    @(negedge clk);
    a53 = 53'd9; b53 = 53'd9; ena53 = 1'b1; ab53 = 1'b1;
    @(negedge clk);
    ena53 = 1'b0; ab53 = 1'b0;
    chk("ab_ena_busy", busy53, 0);
    chk("idle_ab_hold", res53, max53 * 128'd3);

    go53(128'd1000, 128'd2000, 0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_busy", busy53, 0);
    chk("mrst_rdy", rdy53, 0);
    chk("mrst_res", res53, 0);
    chk("mrst_sh", sh53, 0);
    chk("mrst_ov", ov53, 0);
    chk("mrst_z", z53, 0);
    repeat (20) @(negedge clk);

    go8(255, 255);
    wt(1, lat);
    chk("lat8", lat, 6);
    chk("res8_fe01", res8, 16'hfe01);
    go8(200, 3);
    wt(1, lat);
    chk("lat8_b2b", lat, 6);
    go8(1, 128);
    wt(1, lat);
    chk("sh8_128", sh8, 7);

    for (int i = 0; i < 1000; i++) begin
      ra = 24'($urandom);
      rb = 24'($urandom);
      if (i == 0) ra = '0;
      if (i == 1) begin ra = '1; rb = '1; end
      if (i % 9 == 2) rb = rb >> (i % 23);
      go24(128'(ra), 128'(rb));
      wt(2, lat);
    end

    repeat (5) @(negedge clk);
    chk("q_empty", q53.size() + q8.size() + q24.size(), 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
